// File: rtl/alu_issue_pkg.sv
// Shared definitions for the ALU issue/writeback stage.
//   - opcode constants for the five legal ALU operations
//   - FSM state encoding
//   - bit positions of the instruction fields
//   - helpers that classify an opcode
package alu_issue_pkg;

    localparam int OP_W   = 3;
    localparam int REG_AW = 3;

    // Instruction layout: [15:13] opcode, [12:10] rd, [9:7] rs, [6:4] rt
    localparam int INSTR_W = 16;
    localparam int OP_HI   = 15;
    localparam int OP_LO   = 13;
    localparam int RD_HI   = 12;
    localparam int RD_LO   = 10;
    localparam int RS_HI   = 9;
    localparam int RS_LO   = 7;
    localparam int RT_HI   = 6;
    localparam int RT_LO   = 4;

    localparam logic [OP_W-1:0] OP_AND = 3'b000;
    localparam logic [OP_W-1:0] OP_OR  = 3'b001;
    localparam logic [OP_W-1:0] OP_ADD = 3'b010;
    localparam logic [OP_W-1:0] OP_SUB = 3'b110;
    localparam logic [OP_W-1:0] OP_SLT = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_EXEC = 2'd2,
        ST_WB   = 2'd3
    } state_t;

    function automatic logic is_legal_op(input logic [OP_W-1:0] op);
        return (op == OP_AND) || (op == OP_OR) || (op == OP_ADD) ||
               (op == OP_SUB) || (op == OP_SLT);
    endfunction

    // Only add and subtract produce a meaningful carry.
    function automatic logic is_arith_op(input logic [OP_W-1:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/alu_issue_regfile_8x16.sv
// Register file for the issue stage.
//   clk, rst_n            clock, asynchronous active-low reset (clears all entries)
//   rd_addr_a/rd_data_a   combinational read port A (rs operand)
//   rd_addr_b/rd_data_b   combinational read port B (rt operand)
//   dbg_addr/dbg_data     combinational debug read port
//   wr_en/wr_addr/wr_data synchronous write port; writes to entry 0 are dropped
module regfile_8x16 #(
    parameter int DATA_W = 16,
    parameter int NREG   = 8,
    parameter int AW     = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [AW-1:0]     rd_addr_a,
    output logic [DATA_W-1:0] rd_data_a,
    input  logic [AW-1:0]     rd_addr_b,
    output logic [DATA_W-1:0] rd_data_b,
    input  logic [AW-1:0]     dbg_addr,
    output logic [DATA_W-1:0] dbg_data,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data
);

    logic [DATA_W-1:0] regs [NREG];
    logic [NREG-1:0]   wr_sel;

    // One-hot write decode; entry 0 is never selected, so it stays at its
    // reset value of zero and every read of r0 returns 0.
    generate
        for (genvar gi = 0; gi < NREG; gi++) begin : g_wr_sel
            if (gi == 0) begin : g_r0
                assign wr_sel[gi] = 1'b0;
            end else begin : g_rn
                assign wr_sel[gi] = wr_en && (wr_addr == AW'(gi));
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (wr_sel[i]) begin
                    regs[i] <= wr_data;
                end
            end
        end
    end

    assign rd_data_a = regs[rd_addr_a];
    assign rd_data_b = regs[rd_addr_b];
    assign dbg_data  = regs[dbg_addr];

endmodule

// File: rtl/alu_issue.sv
// Issue/writeback stage around an external combinational 16-bit ALU.
// Accepts one instruction per four cycles (IDLE -> READ -> EXEC -> WB),
// reads rs/rt from the register file, presents them to the ALU, captures
// the result and writes it back to rd.
//   clk, rst_n               clock, asynchronous active-low reset
//   instr_valid/instr_ready  instruction handshake; instr is the word
//   alu_x, alu_y, alu_op     ALU operands/opcode, stable outside EXEC
//   alu_result, alu_cout     combinational ALU response
//   done, err                registered one-cycle pulses during WB
//   flag_c                   sticky carry from the last add/subtract
//   dbg_addr, dbg_data       combinational register debug read
module alu_issue
    import alu_issue_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int NREG   = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [15:0]       instr,
    output logic [DATA_W-1:0] alu_x,
    output logic [DATA_W-1:0] alu_y,
    output logic [2:0]        alu_op,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_cout,
    output logic              done,
    output logic              err,
    output logic              flag_c,
    input  logic [2:0]        dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    state_t state_reg, state_next;

    logic [INSTR_W-1:0] ir;
    logic [DATA_W-1:0]  x_q, y_q, res_q;
    logic               c_q;
    logic [OP_W-1:0]    op_q;
    logic               done_reg, err_reg, flag_c_reg;

    logic [OP_W-1:0]    ir_op;
    logic [REG_AW-1:0]  ir_rd, ir_rs, ir_rt;
    logic [DATA_W-1:0]  rs_data, rt_data;
    logic               wr_en;
    logic               unused_ir_bits;

    assign ir_op = ir[OP_HI:OP_LO];
    assign ir_rd = ir[RD_HI:RD_LO];
    assign ir_rs = ir[RS_HI:RS_LO];
    assign ir_rt = ir[RT_HI:RT_LO];
    assign unused_ir_bits = ^ir[RT_LO-1:0];

    // Illegal opcodes walk through WB without touching the register file;
    // rd == 0 is filtered inside the register file.
    assign wr_en = (state_reg == ST_WB) && is_legal_op(ir_op);

    regfile_8x16 #(
        .DATA_W (DATA_W),
        .NREG   (NREG),
        .AW     (REG_AW)
    ) u_regfile (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_addr_a (ir_rs),
        .rd_data_a (rs_data),
        .rd_addr_b (ir_rt),
        .rd_data_b (rt_data),
        .dbg_addr  (dbg_addr),
        .dbg_data  (dbg_data),
        .wr_en     (wr_en),
        .wr_addr   (ir_rd),
        .wr_data   (res_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (instr_valid) state_next = ST_READ;
            ST_READ: state_next = ST_EXEC;
            ST_EXEC: state_next = ST_WB;
            ST_WB:   state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    assign instr_ready = (state_reg == ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir         <= '0;
            x_q        <= '0;
            y_q        <= '0;
            res_q      <= '0;
            c_q        <= 1'b0;
            op_q       <= '0;
            done_reg   <= 1'b0;
            err_reg    <= 1'b0;
            flag_c_reg <= 1'b0;
        end else begin
            // Pulses are set on the EXEC->WB edge so they are high exactly in WB.
            done_reg <= (state_reg == ST_EXEC);
            err_reg  <= (state_reg == ST_EXEC) && !is_legal_op(ir_op);
            case (state_reg)
                ST_IDLE: begin
                    if (instr_valid) begin
                        ir <= instr;
                    end
                end
                ST_READ: begin
                    // Operands and opcode change only here, so the ALU inputs
                    // are stable during EXEC and hold through WB/IDLE/READ.
                    x_q  <= rs_data;
                    y_q  <= rt_data;
                    op_q <= ir_op;
                end
                ST_EXEC: begin
                    res_q <= alu_result;
                    if (is_arith_op(ir_op)) begin
                        c_q <= alu_cout;
                    end
                end
                ST_WB: begin
                    if (is_arith_op(ir_op)) begin
                        flag_c_reg <= c_q;
                    end
                end
                default: ;
            endcase
        end
    end

    assign alu_x  = x_q;
    assign alu_y  = y_q;
    assign alu_op = op_q;
    assign done   = done_reg;
    assign err    = err_reg;
    assign flag_c = flag_c_reg;

endmodule

// File: doc/alu_issue.md
# alu_issue

Sequential issue/writeback stage wrapped around the combinational 16-bit ALU in the microprocessor datapath. It accepts an instruction word over a valid/ready handshake and reads two source operands from an internal 8-entry register file. It then drives X, Y and the 3-bit opcode into the ALU, captures the result and writes it back to the destination register. One instruction completes every four cycles; the ALU itself stays purely combinational.

## Interface
- DATA_W, 16, datapath and register width
- NREG, 8, register count; register addresses are 3 bits
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous and active-low
- instr_valid  in  1  instruction word present
- instr_ready  out  1  block can accept an instruction
- instr  in  16  instruction: [15:13] opcode, [12:10] rd, [9:7] rs, [6:4] rt, [3:0] ignored
- alu_x  out  DATA_W  ALU X operand
- alu_y  out  DATA_W  ALU Y operand
- alu_op  out  3  ALU opcode
- alu_result  in  DATA_W  ALU output, combinational from alu_x/alu_y/alu_op
- alu_cout  in  1  ALU carry out
- done  out  1  one-cycle pulse when writeback completes
- err  out  1  one-cycle pulse on an illegal opcode
- flag_c  out  1  sticky carry from the last add/subtract
- dbg_addr  in  3  debug register read address
- dbg_data  out  DATA_W  combinational read of regs[dbg_addr]

## Operation
- Legal opcodes:
  - 000 AND
  - 001 OR
  - 010 add
  - 110 subtract
  - 111 set-on-less-than
- Opcodes 011, 100 and 101 are illegal.
- FSM states are IDLE, READ, EXEC and WB.
- IDLE:
  - instr_ready = 1.
  - On instr_valid && instr_ready, latch instr into ir and go to READ.
- READ:
  - Latch x_q = regs[rs] and y_q = regs[rt].
  - Go to EXEC.
- EXEC:
  - alu_x = x_q, alu_y = y_q, alu_op = ir opcode.
  - Capture res_q = alu_result.
  - On add or subtract, also capture c_q = alu_cout.
  - Go to WB.
- WB:
  - For a legal opcode with rd != 0: regs[rd] <= res_q.
  - On add or subtract, flag_c <= c_q.
  - done = 1; go to IDLE.
- Illegal opcode:
  - The FSM passes through the same states.
  - In WB: err = 1, done = 1, no register write, flag_c unchanged.
- Register 0 always reads 0; writes to it are discarded, and done still pulses.
- Outside EXEC, alu_x, alu_y and alu_op hold their last values. This keeps the ALU inputs stable, and no glitch-driven output matters.
- dbg_data shows the pre-write value during the WB cycle and the new value from the next cycle.
- rs == rd or rt == rd is legal; the operands are the old values.
- instr_valid while busy is ignored: no queueing, and the upstream block holds the word.

## Timing
- Reset values:
  - state = IDLE, instr_ready = 1.
  - alu_x = 0, alu_y = 0, alu_op = 0.
  - done = 0, err = 0, flag_c = 0.
  - All registers = 0.
  - ir, x_q, y_q, res_q and c_q = 0.
- Handshake cycle is t0.
- Timeline:
  - t1: READ, instr_ready = 0.
  - t2: EXEC, ALU inputs valid.
  - t3: WB, done high, register written at the t3→t4 edge.
  - t4: IDLE, instr_ready = 1, and a new instruction can be accepted in the same cycle.
- Throughput: 1 instruction per 4 cycles. Latency from acceptance to register visible on dbg_data: 4 cycles.
- done and err are registered pulses, each exactly 1 cycle wide.
- Asynchronous reset at any state aborts the operation with no partial write. The block is ready in the first cycle after rst_n deasserts.

## Structure
- Shared package holds:
  - opcode constants: OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT
  - FSM state encoding
  - instruction field bit positions
  - an is_legal_op function
- Natural sub-module: regfile_8x16
  - async-reset array
  - two combinational read ports plus the debug read port
  - one synchronous write port, with r0 forced to zero
- FSM and ALU-side registers stay in alu_issue.

## Test plan
- Reset, then a debug read of all registers → each reads 0, instr_ready = 1, flag_c = 0.
- Preload via add: issue add r1 = r0 + r0 → r1 = 0, then issue OR and add sequences from a seeded model to load r1 = 0x1234 and r2 = 0x0F0F. Issue add r3 = r1 + r2 → r3 = 0x2143, done at t3, instr_ready low for t1–t3.
- r4 = 0xFFFF and r5 = 0x0001; add r6 = r4 + r5 → r6 = 0x0000, flag_c = 1. A following AND leaves flag_c = 1.
- Illegal opcode 100 with rd = 3 → err and done pulse for 1 cycle, r3 unchanged.
- Write to r0 (OR r0 = r1 | r2) → r0 still reads 0 and done pulses. In a separate check, rs == rd (add r1 = r1 + r1 with r1 = 0x0002) → r1 = 0x0004.
- Assert rst_n low during EXEC of add r7 → r7 = 0, state IDLE, no done pulse. Back-to-back valid held high → accept exactly every 4th cycle.
